// File: rtl/jtcontra_obj_dma.sv
// -----------------------------------------------------------------------------
// jtcontra_obj_dma
//
// Object-table DMA for the 007121 sprite path. On the falling edge of LVBL the
// 320-byte object table is copied from the shared CPU object RAM into a private
// scan buffer, which the object line engine reads through scan_addr/obj_scan.
//
// Optional feature macro: JTCONTRA_OBJ_DBUF_EN
//   defined     : two 512x8 banks; the DMA fills the bank not being read and
//                 the banks swap when the copy completes.
//   not defined : a single 512x8 bank; scan reads during a copy may see a mix
//                 of old and new bytes.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   LVBL       in   vertical blank (active low); falling edge starts a copy
//   cpu_busy   in   CPU owns the object-RAM port this cycle (stalls the DMA)
//   dma_cs     out  object-RAM read request (combinational from cpu_busy)
//   dma_addr   out  object-RAM read address
//   dma_din    in   object-RAM read data, valid the cycle after an issued read
//   scan_addr  in   scan-buffer read address from the line engine
//   obj_scan   out  scan-buffer data, one-cycle latency
//   busy       out  copy in progress
//   done       out  one-cycle pulse when a copy completes
// -----------------------------------------------------------------------------
module jtcontra_obj_dma #(
    parameter int OBJ_BYTES = 320
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       LVBL,
    input  logic       cpu_busy,
    output logic       dma_cs,
    output logic [9:0] dma_addr,
    input  logic [7:0] dma_din,
    input  logic [9:0] scan_addr,
    output logic [7:0] obj_scan,
    output logic       busy,
    output logic       done
);

    localparam logic [9:0] LAST_ADDR = 10'(OBJ_BYTES - 1);
    localparam logic [9:0] SIZE_ADDR = 10'(OBJ_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic       lvbl_last_r;
    logic       start_s;
    logic       issue_s;
    logic       last_issue_s;
    logic       wr_pend_r;
    logic [8:0] wr_addr_r;
    logic [9:0] dma_addr_r;
    logic       busy_r;
    logic       done_r;
    logic [7:0] obj_scan_r;

`ifdef JTCONTRA_OBJ_DBUF_EN
    logic       rd_bank_r;
    logic [7:0] buf_mem [0:1023];
    logic [9:0] wr_idx_s;
    logic [9:0] rd_idx_s;

    // The DMA always fills the bank that the scan side is not reading.
    assign wr_idx_s = {~rd_bank_r, wr_addr_r};
    assign rd_idx_s = {rd_bank_r, scan_addr[8:0]};
`else
    logic [7:0] buf_mem [0:511];
    logic [8:0] wr_idx_s;
    logic [8:0] rd_idx_s;

    assign wr_idx_s = wr_addr_r;
    assign rd_idx_s = scan_addr[8:0];
`endif

    assign start_s      = ~LVBL & lvbl_last_r;
    assign issue_s      = (state_r == ST_COPY) & ~cpu_busy;
    assign last_issue_s = issue_s & (dma_addr_r == LAST_ADDR);

    assign dma_cs   = issue_s;
    assign dma_addr = dma_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign obj_scan = obj_scan_r;

    // Copy sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Copy sequencer next-state logic; start edges outside IDLE are ignored.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_COPY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COPY: begin
                if (last_issue_s) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_COPY;
                end
            end
            ST_FLUSH: state_s = ST_SWAP;
            ST_SWAP:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // LVBL edge history, read address counter, write pipeline and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvbl_last_r <= 1'b1;
            dma_addr_r  <= 10'd0;
            wr_pend_r   <= 1'b0;
            wr_addr_r   <= 9'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            lvbl_last_r <= LVBL;
            // The counter parks on the last address until the copy wraps up.
            if (state_s == ST_SWAP) begin
                dma_addr_r <= 10'd0;
            end else if (issue_s && !last_issue_s) begin
                dma_addr_r <= dma_addr_r + 10'd1;
            end else begin
                dma_addr_r <= dma_addr_r;
            end
            // Data for an issued read arrives next cycle; that write is
            // committed even if cpu_busy rises meanwhile.
            wr_pend_r <= issue_s;
            if (issue_s) begin
                wr_addr_r <= dma_addr_r[8:0];
            end else begin
                wr_addr_r <= wr_addr_r;
            end
            busy_r <= (state_s == ST_COPY) || (state_s == ST_FLUSH);
            done_r <= (state_s == ST_SWAP);
        end
    end

`ifdef JTCONTRA_OBJ_DBUF_EN
    // Bank swap on the edge that enters SWAP, together with the final write,
    // so scan addresses sampled during the done pulse already see the new table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank_r <= 1'b0;
        end else if (state_r == ST_FLUSH) begin
            rd_bank_r <= ~rd_bank_r;
        end else begin
            rd_bank_r <= rd_bank_r;
        end
    end
`endif

    // Scan buffer write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_pend_r) begin
            buf_mem[wr_idx_s] <= dma_din;
        end
    end

    // Scan buffer read port; a same-cycle write to the same cell returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_scan_r <= 8'd0;
        end else if (scan_addr >= SIZE_ADDR) begin
            obj_scan_r <= 8'd0;
        end else begin
            obj_scan_r <= buf_mem[rd_idx_s];
        end
    end

endmodule

// File: tb/tb_jtcontra_obj_dma.sv
// -----------------------------------------------------------------------------
// tb_jtcontra_obj_dma
//
// Self-checking bench for jtcontra_obj_dma. Keeps its own object RAM and an
// abstract picture of the scan buffer (a table per bank plus which bank is
// visible), updated only when a whole copy completes or a reset abandons one.
// Works with and without JTCONTRA_OBJ_DBUF_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtcontra_obj_dma;

    localparam int N = 320;
`ifdef JTCONTRA_OBJ_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       LVBL;
    logic       cpu_busy;
    logic       dma_cs;
    logic [9:0] dma_addr;
    logic [7:0] dma_din;
    logic [9:0] scan_addr;
    logic [7:0] obj_scan;
    logic       busy;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] orm   [0:1023];
    logic [7:0] model [0:1][0:N-1];
    bit         known [0:1];
    bit         rd_bank;
    int         issued[$];

    always #5 clk = ~clk;

    jtcontra_obj_dma #(.OBJ_BYTES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .LVBL      (LVBL),
        .cpu_busy  (cpu_busy),
        .dma_cs    (dma_cs),
        .dma_addr  (dma_addr),
        .dma_din   (dma_din),
        .scan_addr (scan_addr),
        .obj_scan  (obj_scan),
        .busy      (busy),
        .done      (done)
    );

    // Object RAM: answers an issued read one cycle later, garbage otherwise.
    always @(posedge clk) begin
        if (dma_cs === 1'b1) begin
            dma_din <= orm[dma_addr];
            issued.push_back(int'(dma_addr));
        end else begin
            dma_din <= 8'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scan read against the abstract buffer model.
    task automatic scan_chk(input logic [9:0] a);
        logic [7:0] e;
        bit         k;
        @(negedge clk);
        scan_addr = a;
        @(negedge clk);
        k = (a >= 10'(N)) || known[rd_bank];
        e = (a >= 10'(N)) ? 8'h00 : model[rd_bank][int'(a)];
        if (k) chk($sformatf("scan_%03h", a), obj_scan, e);
    endtask

    // Scan read against a fixed expected byte.
    task automatic scan_eq(input logic [9:0] a, input logic [7:0] e);
        @(negedge clk);
        scan_addr = a;
        @(negedge clk);
        chk($sformatf("scan_fixed_%03h", a), obj_scan, e);
    endtask

    // A completed copy installs the object RAM snapshot in the write bank.
    task automatic commit_copy();
        bit wb;
        wb = DBUF ? ~rd_bank : 1'b0;
        for (int i = 0; i < N; i++) model[wb][i] = orm[i];
        known[wb] = 1'b1;
        rd_bank = DBUF ? ~rd_bank : 1'b0;
    endtask

    // One full copy. stall_mode: 0 none, 1 toggle every cycle, 2 random.
    // Negedge n lies between edges T(n-1) and Tn, i.e. shows what Tn samples.
    task automatic do_copy(input int stall_mode, input int retrig_at, input int probe_at,
                           input logic [9:0] probe_addr, input logic [7:0] probe_exp);
        int         done_n;
        int         done_cnt;
        int         stalls;
        int         post_n;
        bit         ok;
        logic [9:0] a2;
        done_n = 0; done_cnt = 0; stalls = 0; post_n = -1; a2 = 10'd0;
        cpu_busy = 1'b0;
        @(negedge clk);
        issued.delete();
        LVBL = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("busy_at_T1", busy, 1);
                chk("cs_at_T1", dma_cs, 1);
            end
            if (n == post_n) chk("new_table_at_done", obj_scan, orm[int'(a2)]);
            if (probe_at > 0 && n == probe_at + 1) chk("probe_during_copy", obj_scan, probe_exp);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_n == 0) begin
                    done_n = n;
                    chk("busy_clear_at_done", busy, 0);
                    a2 = 10'($urandom_range(N - 1));
                    scan_addr = a2;
                    post_n = n + 1;
                end
            end
            if (n == probe_at) scan_addr = probe_addr;
            if (n == 5) LVBL = 1'b1;
            if (retrig_at > 0 && n == retrig_at) LVBL = 1'b0;
            if (retrig_at > 0 && n == retrig_at + 5) LVBL = 1'b1;
            case (stall_mode)
                1:       cpu_busy = n[0];
                2:       cpu_busy = ($urandom_range(3) == 0);
                default: cpu_busy = 1'b0;
            endcase
            if (cpu_busy && issued.size() < N) stalls++;
            if (done_n != 0 && n >= done_n + 3) break;
        end
        cpu_busy = 1'b0;
        LVBL = 1'b1;
        chk("done_cycle", done_n, 322 + stalls);
        chk("done_pulses", done_cnt, 1);
        chk("issue_count", issued.size(), N);
        ok = 1'b1;
        foreach (issued[i]) if (issued[i] != i) ok = 1'b0;
        chk("issue_sequence", ok, 1);
        chk("idle_after_copy", busy, 0);
        if (stall_mode == 1) chk("toggle_done_window", (done_n >= 641 && done_n <= 643), 1);
    endtask

    initial begin
        int nw;
        bit wb;
        LVBL = 1'b1; cpu_busy = 1'b0; scan_addr = 10'd0; rst_n = 1'b1;
        rd_bank = 1'b0; known[0] = 1'b0; known[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dma_cs", dma_cs, 0);
        chk("rst_dma_addr", dma_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_obj_scan", obj_scan, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_edge", busy, 0);

        // Basic copy
        for (int i = 0; i < 1024; i++) orm[i] = 8'(i) ^ 8'h5A;
        do_copy(0, 0, 0, 10'd0, 8'h00);
        commit_copy();
        scan_eq(10'h000, 8'h5A);
        scan_eq(10'h0A7, 8'hFD);
        scan_eq(10'h13F, 8'h65);

        // Out of range
        scan_eq(10'h140, 8'h00);
        scan_eq(10'h3FF, 8'h00);
        scan_eq(10'h200, 8'h00);

        // Stalls on alternate cycles, same table
        do_copy(1, 0, 0, 10'd0, 8'h00);
        commit_copy();
        scan_eq(10'h0A7, 8'hFD);
        for (int i = 0; i < 6; i++) scan_chk(10'($urandom_range(N - 1)));

        // Double-buffer visibility
        for (int i = 0; i < 1024; i++) orm[i] = 8'h11;
        do_copy(0, 0, 0, 10'd0, 8'h00);
        commit_copy();
        for (int i = 0; i < 1024; i++) orm[i] = 8'h22;
        do_copy(0, 0, 200, 10'h050, DBUF ? 8'h11 : 8'h22);
        commit_copy();
        scan_eq(10'h050, 8'h22);
        scan_eq(10'h000, 8'h22);

        // Retrigger during copy is ignored
        for (int i = 0; i < 1024; i++) orm[i] = 8'($urandom);
        do_copy(0, 100, 0, 10'd0, 8'h00);
        commit_copy();
        repeat (20) @(negedge clk);
        chk("no_second_copy", busy, 0);
        for (int i = 0; i < 4; i++) scan_chk(10'($urandom_range(N - 1)));

        // Random frames with random stalls
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 1024; i++) orm[i] = 8'($urandom);
            do_copy(2, 0, 0, 10'd0, 8'h00);
            commit_copy();
            for (int i = 0; i < 6; i++) scan_chk(10'($urandom_range(1023)));
        end

        // Reset mid-copy
        for (int i = 0; i < 1024; i++) orm[i] = 8'($urandom);
        @(negedge clk);
        scan_addr = 10'h010;
        issued.delete();
        LVBL = 1'b0;
        @(posedge clk);
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_dma_cs", dma_cs, 0);
        chk("midrst_obj_scan", obj_scan, 0);
        chk("midrst_done", done, 0);
        // Every issued read except the last already had its write edge.
        nw = issued.size() - 1;
        wb = DBUF ? ~rd_bank : 1'b0;
        for (int i = 0; i < nw; i++) model[wb][i] = orm[i];
        rd_bank = 1'b0;
        LVBL = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_idle", busy, 0);
        scan_chk(10'h010);
        scan_chk(10'h0F0);
        scan_chk(10'h130);
        do_copy(0, 0, 0, 10'd0, 8'h00);
        commit_copy();
        for (int i = 0; i < 6; i++) scan_chk(10'($urandom_range(N - 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
